// File: rtl/game_seq_ctrl.sv
// SuperFrog game sequencer: IDLE/PLAY/DYING/RESPAWN/OVER flow with lives, score and level.
// Optional macro GAME_SEQ_BONUS_LIFE_EN grants an extra life on every 64-dodge boundary.
module game_seq_ctrl #(
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 120,
    parameter int SCORE_W      = 10,
    parameter int LEVEL_UP     = 16,
    parameter int MAX_LEVEL    = 7,
    parameter int LVL_W        = 3
) (
    input  logic               clk_pix,
    input  logic               rst_pix,
    input  logic               frame,
    input  logic               btn_start,
    input  logic               hit,
    input  logic               dodge,
    output logic [2:0]         state,
    output logic               play_en,
    output logic               spr_rst,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [LVL_W-1:0]   level,
    output logic               game_over
);

    localparam int TMR_W = $clog2(DEATH_FRAMES + 1);
    localparam int CNT_W = $clog2(LEVEL_UP + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_DYING   = 3'd2,
        S_RESPAWN = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t             state_q;
    logic               play_en_q;
    logic               spr_rst_q;
    logic [2:0]         lives_q;
    logic [SCORE_W-1:0] score_q;
    logic [LVL_W-1:0]   level_q;
    logic               game_over_q;
    logic [TMR_W-1:0]   timer_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               armed_q;

    logic               start_ev;
    logic               score_max;
    logic [SCORE_W-1:0] score_d;
    logic [LVL_W-1:0]   level_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               cnt_wrap;
    logic [2:0]         lives_d;

    always_comb begin
        start_ev  = frame && btn_start && armed_q;
        score_max = &score_q;
        score_d   = score_max ? score_q : score_q + SCORE_W'(1);
        level_d   = (level_q >= LVL_W'(MAX_LEVEL)) ? level_q : level_q + LVL_W'(1);
        cnt_d     = cnt_q + CNT_W'(1);
        cnt_wrap  = (cnt_d == CNT_W'(LEVEL_UP));
`ifdef GAME_SEQ_BONUS_LIFE_EN
        // A real increment that wraps the low six score bits earns a life.
        if ((score_q[5:0] == 6'h3F) && !score_max && (lives_q != 3'd7))
            lives_d = lives_q + 3'd1;
        else
            lives_d = lives_q;
`else
        lives_d = lives_q;
`endif
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q     <= S_IDLE;
            play_en_q   <= 1'b0;
            spr_rst_q   <= 1'b0;
            lives_q     <= 3'd0;
            score_q     <= '0;
            level_q     <= '0;
            game_over_q <= 1'b0;
            timer_q     <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
        end else begin
            spr_rst_q <= 1'b0;
            if (frame && !btn_start)
                armed_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start_ev) begin
                        state_q   <= S_PLAY;
                        play_en_q <= 1'b1;
                        spr_rst_q <= 1'b1;
                        lives_q   <= 3'(LIVES);
                        score_q   <= '0;
                        level_q   <= '0;
                        cnt_q     <= '0;
                        armed_q   <= 1'b0;
                    end
                end
                S_PLAY: begin
                    // A collision outranks a dodge in the same cycle.
                    if (hit) begin
                        state_q   <= S_DYING;
                        play_en_q <= 1'b0;
                        timer_q   <= TMR_W'(DEATH_FRAMES - 1);
                    end else if (dodge) begin
                        score_q <= score_d;
                        lives_q <= lives_d;
                        if (cnt_wrap) begin
                            cnt_q   <= '0;
                            level_q <= level_d;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                S_DYING: begin
                    if (frame) begin
                        if (timer_q != '0) begin
                            timer_q <= timer_q - TMR_W'(1);
                        end else if (lives_q <= 3'd1) begin
                            state_q     <= S_OVER;
                            lives_q     <= 3'd0;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q   <= S_RESPAWN;
                            lives_q   <= lives_q - 3'd1;
                            spr_rst_q <= 1'b1;
                        end
                    end
                end
                S_RESPAWN: begin
                    if (frame) begin
                        state_q   <= S_PLAY;
                        play_en_q <= 1'b1;
                    end
                end
                S_OVER: begin
                    if (start_ev) begin
                        state_q     <= S_IDLE;
                        game_over_q <= 1'b0;
                        armed_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    play_en_q   <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign state     = state_q;
    assign play_en   = play_en_q;
    assign spr_rst   = spr_rst_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign level     = level_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl: vector table for the start flow, hand sequences for
// scoring, death/respawn, game over, async reset and the optional bonus life.
module tb_game_seq_ctrl;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic       frame = 1'b0;
    logic       btn_start = 1'b0;
    logic       hit = 1'b0;
    logic       dodge = 1'b0;
    logic [2:0] state;
    logic       play_en;
    logic       spr_rst;
    logic [2:0] lives;
    logic [9:0] score;
    logic [2:0] level;
    logic       game_over;

    int total = 0;
    int bad = 0;

    game_seq_ctrl dut (
        .clk_pix  (clk_pix),
        .rst_pix  (rst_pix),
        .frame    (frame),
        .btn_start(btn_start),
        .hit      (hit),
        .dodge    (dodge),
        .state    (state),
        .play_en  (play_en),
        .spr_rst  (spr_rst),
        .lives    (lives),
        .score    (score),
        .level    (level),
        .game_over(game_over)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic       f, b, h, d;
        logic [2:0] st;
        logic       pe, sr;
        logic [2:0] lv;
        logic [9:0] sc;
        logic [2:0] lvl;
        logic       go;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic f, input logic b, input logic h, input logic d,
                                input logic [2:0] st, input logic pe, input logic sr,
                                input logic [2:0] lv, input logic [9:0] sc,
                                input logic [2:0] lvl, input logic go);
        vec_t v;
        v.f = f; v.b = b; v.h = h; v.d = d;
        v.st = st; v.pe = pe; v.sr = sr; v.lv = lv; v.sc = sc; v.lvl = lvl; v.go = go;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] st, input logic pe,
                             input logic sr, input logic [2:0] lv, input logic [9:0] sc,
                             input logic [2:0] lvl, input logic go);
        check({name, ".state"}, int'(state), int'(st));
        check({name, ".play_en"}, int'(play_en), int'(pe));
        check({name, ".spr_rst"}, int'(spr_rst), int'(sr));
        check({name, ".lives"}, int'(lives), int'(lv));
        check({name, ".score"}, int'(score), int'(sc));
        check({name, ".level"}, int'(level), int'(lvl));
        check({name, ".game_over"}, int'(game_over), int'(go));
    endtask

    // One clock of stimulus, driven at the falling edge, sampled 1 ns after the rising edge.
    task automatic step(input logic f, input logic b, input logic h, input logic d);
        @(negedge clk_pix);
        frame = f; btn_start = b; hit = h; dodge = d;
        @(posedge clk_pix);
        #1;
        frame = 1'b0; btn_start = 1'b0; hit = 1'b0; dodge = 1'b0;
    endtask

    task automatic dodges(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic death_seq(input logic [2:0] lives_after, input logic [9:0] sc,
                             input logic [2:0] lvl);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("hit_to_dying.state", int'(state), 2);
        check("hit_to_dying.play_en", int'(play_en), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("dodge_in_dying.score", int'(score), int'(sc));
        for (int i = 0; i < 119; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("dying_after_119.state", int'(state), 2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        if (lives_after == 3'd0) begin
            check_all("dying_to_over", 3'd4, 1'b0, 1'b0, 3'd0, sc, lvl, 1'b1);
        end else begin
            check_all("dying_to_respawn", 3'd3, 1'b0, 1'b1, lives_after, sc, lvl, 1'b0);
            step(1'b0, 1'b0, 1'b0, 0);
            check("respawn_wait.state", int'(state), 3);
            check("respawn_wait.spr_rst", int'(spr_rst), 0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check_all("respawn_to_play", 3'd1, 1'b1, 1'b0, lives_after, sc, lvl, 1'b0);
        end
    endtask

    logic [2:0] exp_bonus;

    initial begin
        // Start-button flow: held button is ignored until released on a sampled frame.
        vecs[0]  = mk(1, 1, 0, 0, 3'd0, 0, 0, 3'd0, 10'd0, 3'd0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 3'd0, 0, 0, 3'd0, 10'd0, 3'd0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 3'd0, 0, 0, 3'd0, 10'd0, 3'd0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 3'd0, 0, 0, 3'd0, 10'd0, 3'd0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 3'd0, 0, 0, 3'd0, 10'd0, 3'd0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 3'd0, 0, 0, 3'd0, 10'd0, 3'd0, 0);
        vecs[6]  = mk(0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 10'd0, 3'd0, 0);
        vecs[7]  = mk(1, 1, 0, 0, 3'd1, 1, 1, 3'd3, 10'd0, 3'd0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 3'd1, 1, 0, 3'd3, 10'd0, 3'd0, 0);
        vecs[9]  = mk(0, 0, 0, 1, 3'd1, 1, 0, 3'd3, 10'd1, 3'd0, 0);
        vecs[10] = mk(1, 0, 0, 1, 3'd1, 1, 0, 3'd3, 10'd2, 3'd0, 0);

        repeat (2) @(posedge clk_pix);
        #1;
        check_all("reset", 3'd0, 1'b0, 1'b0, 3'd0, 10'd0, 3'd0, 1'b0);
        @(negedge clk_pix);
        rst_pix = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].f, vecs[i].b, vecs[i].h, vecs[i].d);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pe, vecs[i].sr,
                      vecs[i].lv, vecs[i].sc, vecs[i].lvl, vecs[i].go);
        end

        // Scoring and level progression from score=2.
        dodges(14);
        check("score16.level", int'(level), 1);
        dodges(17);
        check_all("score33", 3'd1, 1'b1, 1'b0, 3'd3, 10'd33, 3'd2, 1'b0);
        dodges(167);
        check_all("score200", 3'd1, 1'b1, 1'b0, 3'd3, 10'd200, 3'd7, 1'b0);

        // Three deaths end the game; score and level hold in OVER.
        death_seq(3'd2, 10'd200, 3'd7);
        death_seq(3'd1, 10'd200, 3'd7);
        death_seq(3'd0, 10'd200, 3'd7);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("over_to_idle", 3'd0, 1'b0, 1'b0, 3'd0, 10'd200, 3'd7, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("held_start_in_idle.state", int'(state), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_all("restart", 3'd1, 1'b1, 1'b1, 3'd3, 10'd0, 3'd0, 1'b0);

        // hit and dodge together: hit wins.
        dodges(10);
        check("score10", int'(score), 10);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_all("hit_and_dodge", 3'd2, 1'b0, 1'b0, 3'd3, 10'd10, 3'd0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-DYING, observed before the next rising edge.
        @(negedge clk_pix);
        rst_pix = 1'b1;
        #2;
        check_all("async_reset", 3'd0, 1'b0, 1'b0, 3'd0, 10'd0, 3'd0, 1'b0);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("after_reset_not_armed.state", int'(state), 0);
        check("after_reset.spr_rst", int'(spr_rst), 0);

        // 64-boundary bonus life.
`ifdef GAME_SEQ_BONUS_LIFE_EN
        exp_bonus = 3'd4;
`else
        exp_bonus = 3'd3;
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("bonus_game_start.state", int'(state), 1);
        dodges(63);
        check_all("score63", 3'd1, 1'b1, 1'b0, 3'd3, 10'd63, 3'd3, 1'b0);
        dodges(1);
        check_all("score64", 3'd1, 1'b1, 1'b0, exp_bonus, 10'd64, 3'd4, 1'b0);
        dodges(63);
        check("score127", int'(score), 127);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_all("boundary_with_hit", 3'd2, 1'b0, 1'b0, exp_bonus, 10'd127, 3'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
